// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the tournament branch predictor.
// Covers the 2-bit counter encodings, their reset value and the chooser polarity.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CtrSnt = 2'b00,
    CtrWnt = 2'b01,
    CtrWt  = 2'b10,
    CtrSt  = 2'b11
  } ctr_e;

  localparam logic [1:0] CtrReset = CtrWnt;

  // Chooser counter MSB set means "trust the global component".
  localparam int unsigned ChoGlobalBit = 1;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state function.
// Shared by the local PHT, global PHT and chooser update paths.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       inc_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    if (inc_i) begin
      if (cur_i != CtrSt) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != CtrSnt) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tournament (local/global/chooser) direction predictor with a speculative GHR.
// Predictions are combinational from table state; training and GHR repair take one edge.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned LHT_BITS = 6,
  parameter int unsigned LHR_BITS = 6,
  parameter int unsigned GHR_BITS = 8,
  parameter int unsigned CHO_BITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                F_valid_i,
  input  logic                F_stall_i,
  input  logic [PC_WIDTH-1:0] F_PC_i,
  output logic                F_predict_o,
  output logic                F_local_predict_o,
  output logic                F_global_predict_o,
  output logic [GHR_BITS-1:0] F_ghr_o,
  input  logic                D_train_valid_i,
  input  logic [PC_WIDTH-1:0] D_PC_i,
  input  logic [GHR_BITS-1:0] D_ghr_i,
  input  logic                D_predict_i,
  input  logic                D_local_predict_i,
  input  logic                D_global_predict_i,
  input  logic                D_train_taken_i,
  input  logic                D_train_local_taken_i,
  input  logic                D_train_global_taken_i
);

  localparam int unsigned LhtEntries  = 1 << LHT_BITS;
  localparam int unsigned LphtEntries = 1 << LHR_BITS;
  localparam int unsigned GphtEntries = 1 << GHR_BITS;
  localparam int unsigned ChoEntries  = 1 << CHO_BITS;

  logic [LHR_BITS-1:0] lht_q  [LhtEntries];
  logic [LHR_BITS-1:0] lht_d  [LhtEntries];
  logic [1:0]          lpht_q [LphtEntries];
  logic [1:0]          lpht_d [LphtEntries];
  logic [1:0]          gpht_q [GphtEntries];
  logic [1:0]          gpht_d [GphtEntries];
  logic [1:0]          cho_q  [ChoEntries];
  logic [1:0]          cho_d  [ChoEntries];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  // Fetch-side lookup.
  logic [LHT_BITS-1:0] f_lidx;
  logic [LHR_BITS-1:0] f_lhr;
  logic [GHR_BITS-1:0] f_gidx;
  logic [CHO_BITS-1:0] f_cidx;

  assign f_lidx = F_PC_i[LHT_BITS+1:2];
  assign f_lhr  = lht_q[f_lidx];
  assign f_gidx = ghr_q ^ F_PC_i[GHR_BITS+1:2];
  assign f_cidx = F_PC_i[CHO_BITS+1:2];

  assign F_local_predict_o  = lpht_q[f_lhr][1];
  assign F_global_predict_o = gpht_q[f_gidx][1];
  assign F_predict_o        = cho_q[f_cidx][ChoGlobalBit] ? F_global_predict_o
                                                          : F_local_predict_o;
  assign F_ghr_o            = ghr_q;

  // Decode-side training; every read here sees pre-write state.
  logic [LHT_BITS-1:0] d_lidx;
  logic [LHR_BITS-1:0] d_lhr;
  logic [GHR_BITS-1:0] d_gidx;
  logic [CHO_BITS-1:0] d_cidx;
  logic                actual, local_actual, global_actual, mispredict;
  logic [1:0]          lpht_next, gpht_next, cho_next;

  assign d_lidx        = D_PC_i[LHT_BITS+1:2];
  assign d_lhr         = lht_q[d_lidx];
  assign d_gidx        = D_ghr_i ^ D_PC_i[GHR_BITS+1:2];
  assign d_cidx        = D_PC_i[CHO_BITS+1:2];
  assign actual        = D_predict_i ~^ D_train_taken_i;
  assign local_actual  = D_local_predict_i ~^ D_train_local_taken_i;
  assign global_actual = D_global_predict_i ~^ D_train_global_taken_i;
  assign mispredict    = D_train_valid_i & ~D_train_taken_i;

  sat_counter2 u_lpht_ctr (
    .cur_i  (lpht_q[d_lhr]),
    .inc_i  (local_actual),
    .next_o (lpht_next)
  );

  sat_counter2 u_gpht_ctr (
    .cur_i  (gpht_q[d_gidx]),
    .inc_i  (global_actual),
    .next_o (gpht_next)
  );

  sat_counter2 u_cho_ctr (
    .cur_i  (cho_q[d_cidx]),
    .inc_i  (D_train_global_taken_i),
    .next_o (cho_next)
  );

  always_comb begin
    lht_d  = lht_q;
    lpht_d = lpht_q;
    gpht_d = gpht_q;
    cho_d  = cho_q;
    if (D_train_valid_i) begin
      lht_d[d_lidx]  = {d_lhr[LHR_BITS-2:0], local_actual};
      lpht_d[d_lhr]  = lpht_next;
      gpht_d[d_gidx] = gpht_next;
      if (D_train_local_taken_i != D_train_global_taken_i) cho_d[d_cidx] = cho_next;
    end
  end

  // Mispredict repair wins over the speculative fetch shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict) begin
      ghr_d = {D_ghr_i[GHR_BITS-2:0], actual};
    end else if (F_valid_i && !F_stall_i) begin
      ghr_d = {ghr_q[GHR_BITS-2:0], F_predict_o};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
      for (int i = 0; i < int'(LhtEntries); i++)  lht_q[i]  <= '0;
      for (int i = 0; i < int'(LphtEntries); i++) lpht_q[i] <= CtrReset;
      for (int i = 0; i < int'(GphtEntries); i++) gpht_q[i] <= CtrReset;
      for (int i = 0; i < int'(ChoEntries); i++)  cho_q[i]  <= CtrReset;
    end else begin
      ghr_q  <= ghr_d;
      lht_q  <= lht_d;
      lpht_q <= lpht_d;
      gpht_q <= gpht_d;
      cho_q  <= cho_d;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{F_PC_i, D_PC_i};

endmodule
